// File: rtl/opcode_cmd_issue.sv
// Assembles opcode/argument byte pairs into SDRAM read/write commands and issues them
// over a req/ack handshake through a two-slot (active + pending) FIFO buffer.
module opcode_cmd_issue #(
  parameter int TIMEOUT = 64,
  parameter int ADDR_W  = 6,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        din,
  input  logic              din_vld,
  output logic              cmd_req,
  output logic              cmd_wr,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [DATA_W-1:0] cmd_wdata,
  input  logic              cmd_ack,
  output logic              err_pulse,
  output logic              drop_pulse
);

  localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  logic          idx_q, idx_d;
  logic [7:0]    opc_q, opc_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic          act_vld_q, act_vld_d, pend_vld_q, pend_vld_d;
  cmd_t          act_q, act_d, pend_q, pend_d;
  logic          err_q, err_d, drop_q, drop_d;

  logic          complete, expire, issue, ack;
  logic [1:0]    op;
  cmd_t          new_cmd;

  assign op       = opc_q[7:6];
  assign complete = idx_q & din_vld;
  // A byte landing in the expiry cycle wins over the timeout.
  assign expire   = idx_q & ~din_vld & (tmr_q == TW'(TIMEOUT - 1));
  assign issue    = complete & ((op == 2'b01) | (op == 2'b10));
  assign ack      = cmd_ack & act_vld_q;
  assign new_cmd  = '{wr: (op == 2'b01), addr: opc_q[ADDR_W-1:0], data: din[DATA_W-1:0]};

  always_comb begin
    idx_d      = idx_q;
    opc_d      = opc_q;
    tmr_d      = tmr_q;
    act_vld_d  = act_vld_q;
    act_d      = act_q;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    drop_d     = 1'b0;
    err_d      = expire | (complete & (op == 2'b11));

    if (!idx_q) begin
      if (din_vld) begin
        opc_d = din;
        idx_d = 1'b1;
        tmr_d = '0;
      end
    end else if (din_vld) begin
      idx_d = 1'b0;
    end else if (expire) begin
      idx_d = 1'b0;
      opc_d = '0;
    end else begin
      tmr_d = tmr_q + 1'b1;
    end

    // Retire first, then place the new command in the first free slot of the post-ack state.
    if (ack) begin
      act_d      = pend_q;
      act_vld_d  = pend_vld_q;
      pend_vld_d = 1'b0;
    end
    if (issue) begin
      if (!act_vld_d) begin
        act_d     = new_cmd;
        act_vld_d = 1'b1;
      end else if (!pend_vld_d) begin
        pend_d     = new_cmd;
        pend_vld_d = 1'b1;
      end else begin
        drop_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q      <= 1'b0;
      opc_q      <= '0;
      tmr_q      <= '0;
      act_vld_q  <= 1'b0;
      act_q      <= '0;
      pend_vld_q <= 1'b0;
      pend_q     <= '0;
      err_q      <= 1'b0;
      drop_q     <= 1'b0;
    end else begin
      idx_q      <= idx_d;
      opc_q      <= opc_d;
      tmr_q      <= tmr_d;
      act_vld_q  <= act_vld_d;
      act_q      <= act_d;
      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;
      err_q      <= err_d;
      drop_q     <= drop_d;
    end
  end

  assign cmd_req    = act_vld_q;
  assign cmd_wr     = act_q.wr;
  assign cmd_addr   = act_q.addr;
  assign cmd_wdata  = act_q.data;
  assign err_pulse  = err_q;
  assign drop_pulse = drop_q;

endmodule

// File: tb/tb_opcode_cmd_issue.sv
// Scenario bench for opcode_cmd_issue: expected commands are queued as frames are driven
// and compared against handshakes captured by a negedge monitor.
module tb_opcode_cmd_issue;
  localparam int TIMEOUT = 64;

  logic       clk = 1'b0, rst_n = 1'b0;
  logic [7:0] din = 8'h00;
  logic       din_vld = 1'b0, cmd_ack = 1'b0;
  logic       cmd_req, cmd_wr, err_pulse, drop_pulse;
  logic [5:0] cmd_addr;
  logic [7:0] cmd_wdata;

  typedef struct packed {
    logic       wr;
    logic [5:0] addr;
    logic [7:0] data;
  } cmd_t;

  cmd_t exp_q[$], obs_q[$];
  cmd_t cur, prev_c, e;
  int   rd_idx, checks, errors;
  int   hs_cnt, err_cnt, drop_cnt, both_cnt, unstable_cnt;
  int   base_err, base_drop, base_hs;
  logic prev_hold = 1'b0;

  opcode_cmd_issue #(.TIMEOUT(TIMEOUT), .ADDR_W(6), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
    .cmd_req(cmd_req), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_ack(cmd_ack), .err_pulse(err_pulse), .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;
  assign cur = {cmd_wr, cmd_addr, cmd_wdata};

  // Monitor: handshakes, pulses and field stability while a request is held unacknowledged.
  always @(negedge clk) begin
    if (cmd_req && cmd_ack) begin
      obs_q.push_back(cur);
      hs_cnt++;
    end
    if (err_pulse) err_cnt++;
    if (drop_pulse) drop_cnt++;
    if (err_pulse && drop_pulse) both_cnt++;
    if (prev_hold && cmd_req && (cur !== prev_c)) unstable_cnt++;
    prev_hold = cmd_req && !cmd_ack && rst_n;
    prev_c    = cur;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    din = b;
    din_vld = 1'b1;
    tick();
    din_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cmd_req, cmd_wr, cmd_addr, cmd_wdata, err_pulse, drop_pulse} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b wr=%b addr=%h data=%h err=%b drop=%b want all 0",
               cmd_req, cmd_wr, cmd_addr, cmd_wdata, err_pulse, drop_pulse);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_ack_tied();
    cmd_ack = 1'b1;
    send(8'h45);
    checks++;
    if (cmd_req !== 1'b0) begin errors++; $display("FAIL t1_req_early got %b want 0", cmd_req); end
    send(8'hA7);
    exp_q.push_back('{wr: 1'b1, addr: 6'h05, data: 8'hA7});
    checks++;
    if ({cmd_req, cmd_wr, cmd_addr, cmd_wdata} !== {1'b1, 1'b1, 6'h05, 8'hA7}) begin
      errors++;
      $display("FAIL t1_fields got req=%b wr=%b addr=%h data=%h want 1 1 05 a7",
               cmd_req, cmd_wr, cmd_addr, cmd_wdata);
    end
    tick();
    checks++;
    if (cmd_req !== 1'b0) begin errors++; $display("FAIL t1_req_clear got %b want 0", cmd_req); end
    cmd_ack = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= obs_q.size()) begin errors++; $display("FAIL t1_sb_missing want %h", e); end
      else begin
        if (obs_q[rd_idx] !== e) begin errors++; $display("FAIL t1_sb got %h want %h", obs_q[rd_idx], e); end
        rd_idx++;
      end
    end
  endtask

  task automatic test_read_held();
    base_hs = hs_cnt;
    cmd_ack = 1'b0;
    send(8'h8C);
    send(8'h00);
    exp_q.push_back('{wr: 1'b0, addr: 6'h0C, data: 8'h00});
    checks++;
    if ({cmd_req, cmd_wr, cmd_addr, cmd_wdata} !== {1'b1, 1'b0, 6'h0C, 8'h00}) begin
      errors++;
      $display("FAIL t2_fields got req=%b wr=%b addr=%h data=%h want 1 0 0c 00",
               cmd_req, cmd_wr, cmd_addr, cmd_wdata);
    end
    repeat (10) tick();
    checks++;
    if (cmd_req !== 1'b1 || unstable_cnt !== 0) begin
      errors++;
      $display("FAIL t2_hold got req=%b unstable=%0d want 1 0", cmd_req, unstable_cnt);
    end
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    checks++;
    if (cmd_req !== 1'b0 || hs_cnt - base_hs !== 1) begin
      errors++;
      $display("FAIL t2_done got req=%b handshakes=%0d want 0 1", cmd_req, hs_cnt - base_hs);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= obs_q.size()) begin errors++; $display("FAIL t2_sb_missing want %h", e); end
      else begin
        if (obs_q[rd_idx] !== e) begin errors++; $display("FAIL t2_sb got %h want %h", obs_q[rd_idx], e); end
        rd_idx++;
      end
    end
  endtask

  task automatic test_drop();
    base_drop = drop_cnt;
    cmd_ack = 1'b0;
    send(8'h41); send(8'h11);
    exp_q.push_back('{wr: 1'b1, addr: 6'h01, data: 8'h11});
    send(8'h42); send(8'h22);
    exp_q.push_back('{wr: 1'b1, addr: 6'h02, data: 8'h22});
    send(8'h43); send(8'h33);
    checks++;
    if (drop_pulse !== 1'b1 || cmd_addr !== 6'h01) begin
      errors++;
      $display("FAIL t3_drop got drop=%b addr=%h want 1 01", drop_pulse, cmd_addr);
    end
    tick();
    checks++;
    if (drop_pulse !== 1'b0) begin errors++; $display("FAIL t3_drop_width got %b want 0", drop_pulse); end
    cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
    checks++;
    if (cmd_req !== 1'b1 || cmd_addr !== 6'h02) begin
      errors++;
      $display("FAIL t3_second got req=%b addr=%h want 1 02", cmd_req, cmd_addr);
    end
    cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
    checks++;
    if (cmd_req !== 1'b0 || drop_cnt - base_drop !== 1) begin
      errors++;
      $display("FAIL t3_end got req=%b drops=%0d want 0 1", cmd_req, drop_cnt - base_drop);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= obs_q.size()) begin errors++; $display("FAIL t3_sb_missing want %h", e); end
      else begin
        if (obs_q[rd_idx] !== e) begin errors++; $display("FAIL t3_sb got %h want %h", obs_q[rd_idx], e); end
        rd_idx++;
      end
    end
  endtask

  task automatic test_reserved_nop();
    base_err = err_cnt;
    base_hs  = hs_cnt;
    cmd_ack = 1'b1;
    send(8'hC0); send(8'h55);
    checks++;
    if (err_pulse !== 1'b1 || cmd_req !== 1'b0) begin
      errors++;
      $display("FAIL t4_reserved got err=%b req=%b want 1 0", err_pulse, cmd_req);
    end
    tick();
    checks++;
    if (err_pulse !== 1'b0) begin errors++; $display("FAIL t4_err_width got %b want 0", err_pulse); end
    send(8'h00); send(8'h55);
    checks++;
    if (err_pulse !== 1'b0 || cmd_req !== 1'b0) begin
      errors++;
      $display("FAIL t4_nop got err=%b req=%b want 0 0", err_pulse, cmd_req);
    end
    repeat (3) tick();
    checks++;
    if (err_cnt - base_err !== 1 || hs_cnt !== base_hs) begin
      errors++;
      $display("FAIL t4_counts got errs=%0d hs=%0d want 1 0", err_cnt - base_err, hs_cnt - base_hs);
    end
    cmd_ack = 1'b0;
  endtask

  task automatic test_timeout();
    base_err = err_cnt;
    cmd_ack = 1'b1;
    send(8'h41);
    repeat (TIMEOUT - 1) tick();
    checks++;
    if (err_pulse !== 1'b0) begin errors++; $display("FAIL t5_early_err got %b want 0", err_pulse); end
    tick();
    checks++;
    if (err_pulse !== 1'b1) begin errors++; $display("FAIL t5_timeout_err got %b want 1", err_pulse); end
    tick();
    send(8'h42); send(8'h99);
    exp_q.push_back('{wr: 1'b1, addr: 6'h02, data: 8'h99});
    checks++;
    if ({cmd_req, cmd_addr, cmd_wdata} !== {1'b1, 6'h02, 8'h99}) begin
      errors++;
      $display("FAIL t5_realign got req=%b addr=%h data=%h want 1 02 99", cmd_req, cmd_addr, cmd_wdata);
    end
    tick();
    send(8'h41);
    repeat (TIMEOUT - 1) tick();
    send(8'h77);
    exp_q.push_back('{wr: 1'b1, addr: 6'h01, data: 8'h77});
    checks++;
    if ({err_pulse, cmd_req, cmd_addr, cmd_wdata} !== {1'b0, 1'b1, 6'h01, 8'h77}) begin
      errors++;
      $display("FAIL t5_expiry_byte got err=%b req=%b addr=%h data=%h want 0 1 01 77",
               err_pulse, cmd_req, cmd_addr, cmd_wdata);
    end
    repeat (2) tick();
    checks++;
    if (err_cnt - base_err !== 1 || cmd_req !== 1'b0) begin
      errors++;
      $display("FAIL t5_counts got errs=%0d req=%b want 1 0", err_cnt - base_err, cmd_req);
    end
    cmd_ack = 1'b0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= obs_q.size()) begin errors++; $display("FAIL t5_sb_missing want %h", e); end
      else begin
        if (obs_q[rd_idx] !== e) begin errors++; $display("FAIL t5_sb got %h want %h", obs_q[rd_idx], e); end
        rd_idx++;
      end
    end
  endtask

  task automatic test_back_to_back_and_reset();
    base_drop = drop_cnt;
    cmd_ack = 1'b0;
    send(8'h41); send(8'hAA);
    exp_q.push_back('{wr: 1'b1, addr: 6'h01, data: 8'hAA});
    send(8'h82); send(8'hBB);
    exp_q.push_back('{wr: 1'b0, addr: 6'h02, data: 8'hBB});
    send(8'h43);
    exp_q.push_back('{wr: 1'b1, addr: 6'h03, data: 8'hCC});
    din = 8'hCC; din_vld = 1'b1; cmd_ack = 1'b1;
    tick();
    din_vld = 1'b0; cmd_ack = 1'b0;
    checks++;
    if ({drop_pulse, cmd_req, cmd_wr, cmd_addr} !== {1'b0, 1'b1, 1'b0, 6'h02}) begin
      errors++;
      $display("FAIL t6_coincident got drop=%b req=%b wr=%b addr=%h want 0 1 0 02",
               drop_pulse, cmd_req, cmd_wr, cmd_addr);
    end
    cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
    checks++;
    if (cmd_req !== 1'b1 || cmd_addr !== 6'h03) begin
      errors++;
      $display("FAIL t6_third got req=%b addr=%h want 1 03", cmd_req, cmd_addr);
    end
    cmd_ack = 1'b1; tick(); cmd_ack = 1'b0;
    checks++;
    if (cmd_req !== 1'b0 || drop_cnt !== base_drop) begin
      errors++;
      $display("FAIL t6_drain got req=%b drops=%0d want 0 0", cmd_req, drop_cnt - base_drop);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (rd_idx >= obs_q.size()) begin errors++; $display("FAIL t6_sb_missing want %h", e); end
      else begin
        if (obs_q[rd_idx] !== e) begin errors++; $display("FAIL t6_sb got %h want %h", obs_q[rd_idx], e); end
        rd_idx++;
      end
    end
    base_hs = hs_cnt; base_err = err_cnt; base_drop = drop_cnt;
    send(8'h44); send(8'hDD);
    send(8'h45); send(8'hEE);
    send(8'h46);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (cmd_req !== 1'b0) begin errors++; $display("FAIL t6_async_reset got req=%b want 0", cmd_req); end
    tick(); tick();
    rst_n = 1'b1;
    cmd_ack = 1'b1;
    repeat (10) tick();
    cmd_ack = 1'b0;
    checks++;
    if (cmd_req !== 1'b0 || hs_cnt !== base_hs || err_cnt !== base_err || drop_cnt !== base_drop) begin
      errors++;
      $display("FAIL t6_post_reset got req=%b hs=%0d errs=%0d drops=%0d want 0 0 0 0",
               cmd_req, hs_cnt - base_hs, err_cnt - base_err, drop_cnt - base_drop);
    end
  endtask

  initial begin
    test_reset();
    test_write_ack_tied();
    test_read_held();
    test_drop();
    test_reserved_nop();
    test_timeout();
    test_back_to_back_and_reset();
    checks++;
    if (both_cnt !== 0 || unstable_cnt !== 0 || rd_idx !== obs_q.size()) begin
      errors++;
      $display("FAIL global got both=%0d unstable=%0d extra_hs=%0d want 0 0 0",
               both_cnt, unstable_cnt, obs_q.size() - rd_idx);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
